serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder reused for WIDTH cycles per operation.
// Operands are accepted in IDLE, added LSB-first in BUSY, presented in DONE.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;
   logic             last;

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = BUSY;
         BUSY: if (last) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Sum bits enter at the MSB so the result is aligned after WIDTH shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  carry_q <= carry_in;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
               carry_q <= fa_co;
               cnt     <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_sr;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases, reset abort,
// backpressure and a random sweep with random consumer stalls.

module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         carry_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         carry_out;

   int           n_checks = 0;
   int           n_errs = 0;
   int           n_in = 0;
   int           n_out = 0;
   logic [W:0]   exp_q[$];
   bit           rand_ready = 0;
   bit           prev_stall = 0;
   logic [W:0]   prev_res;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] got,
                      input logic [32:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Inputs are stable from #1 after a rising edge, so the falling
   // edge sees exactly what the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {carry_out, sum}, prev_res);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, carry_in});
            n_in++;
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0)
               chk("unexpected_out", {carry_out, sum}, 33'h1_FFFF_FFFF);
            else
               chk("result", {carry_out, sum}, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = {carry_out, sum};
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
      int n = 0;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      carry_in = c;
      while (!in_ready && n < 300) begin
         tick;
         n++;
      end
      if (n >= 300) chk("accept_timeout", n, 0);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         tick;
         n++;
      end
   endtask

   initial begin
      int lat;
      int n;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", {carry_out, sum}, 0);
      tick;
      tick;
      rst_n = 1'b1;

      out_ready = 1'b1;
      send(8'h5A, 8'h33, 1'b0);
      wait_out(lat);
      chk("basic_latency", lat, W);
      chk("basic_sum", {carry_out, sum}, 9'h08D);
      tick;
      chk("basic_ready_after", in_ready, 1);
      chk("basic_valid_after", out_valid, 0);

      send(8'hFF, 8'h01, 1'b0);
      wait_out(lat);
      chk("ripple_sum", {carry_out, sum}, 9'h100);
      tick;

      send(8'hFF, 8'hFF, 1'b1);
      wait_out(lat);
      chk("max_sum", {carry_out, sum}, 9'h1FF);
      tick;

      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0);
      chk("busy_in_ready", in_ready, 0);
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'h55;
      wait_out(lat);
      chk("bp_latency", lat, W);
      repeat (5) tick;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", {carry_out, sum}, 9'h046);
      chk("bp_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);

      send(8'h55, 8'h66, 1'b1);
      tick;
      tick;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_outputs", {carry_out, sum}, 0);
      exp_q.delete();
      n_in  = 0;
      n_out = 0;
      tick;
      tick;
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         if (out_valid) n++;
         tick;
      end
      chk("abort_no_valid", n, 0);
      send(8'h01, 8'h02, 1'b0);
      wait_out(lat);
      chk("post_reset_sum", {carry_out, sum}, 9'h003);
      tick;

      rand_ready = 1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) tick;
         send(W'($urandom), W'($urandom), 1'($urandom));
      end
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick;
         n++;
      end
      rand_ready = 0;
      chk("drain", exp_q.size(), 0);
      chk("handshakes", n_out, n_in);
      chk("accepted", n_in, 1001);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errs);
      $finish;
   end

endmodule
